// File: rtl/load_counter_scheduler_pkg.sv
// Shared types and helpers for the round-robin load-counter scheduler.
// No logic of its own; state encoding plus the ID-width helper.
// No backpressure here; consumers import and use the definitions.
package load_sched_pkg;

  // Session phases: accept in IDLE, strobe the counter in LOAD,
  // watch Count in RUN, signal completion in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/load_counter_scheduler_if.sv
// Bundles the requester handshake and the counter port of the scheduler.
// Wires only, so it adds no latency.
// Backpressure is carried by Req_Ready, which is driven by the scheduler.
interface load_counter_scheduler_if
  import load_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       Req_Valid;
  logic [NUM_REQ-1:0]       Req_Ready;
  logic [NUM_REQ*WIDTH-1:0] Req_Start;
  logic [NUM_REQ*WIDTH-1:0] Req_Stop;
  logic [NUM_REQ-1:0]       Done_Valid;
  logic                     Busy;
  logic [ID_W-1:0]          Grant_Id;
  logic                     Load_Value_Valid;
  logic [WIDTH-1:0]         Load_Value;
  logic [WIDTH-1:0]         Count;

  // Environment side: requesters plus the shared counter.
  modport master (
    output Req_Valid, Req_Start, Req_Stop, Count,
    input  Req_Ready, Done_Valid, Busy, Grant_Id, Load_Value_Valid, Load_Value
  );

  // Scheduler side.
  modport slave (
    input  Req_Valid, Req_Start, Req_Stop, Count,
    output Req_Ready, Done_Valid, Busy, Grant_Id, Load_Value_Valid, Load_Value
  );

endinterface

// File: rtl/load_counter_scheduler_rr_arbiter.sv
// One-hot round-robin pick; the search starts just above the last winner.
// Purely combinational, zero latency.
// No backpressure; the grant is all-zero when nothing is requested.
module rr_arbiter
  import load_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pool;

  // Requesters strictly above the last winner get the first look.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (i > int'(i_last_grant));
    end
  end

  assign w_masked = i_req & w_mask;
  // Nothing above the pointer: wrap around to the full request set.
  assign w_pool   = (|w_masked) ? w_masked : i_req;
  // Isolate the lowest set bit of the chosen pool.
  assign o_grant  = w_pool & (~w_pool + NUM_REQ'(1));

endmodule

// File: rtl/load_counter_scheduler.sv
// Shares one loadable up-counter among round-robin requesters, one session at a time.
// Session = accept, one load cycle, (stop-start mod 2^WIDTH)+1 run cycles, one done cycle.
// Only one request is accepted, and only in IDLE; the others stay pending on Req_Valid.
module load_counter_scheduler
  import load_sched_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input logic Clk,
  input logic Rst_l,
  load_counter_scheduler_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_id_q;
  logic [ID_W-1:0]    w_pick_id;
  logic [WIDTH-1:0]   r_stop_q;
  logic [WIDTH-1:0]   r_load_value;
  logic [WIDTH-1:0]   w_pick_start;
  logic [WIDTH-1:0]   w_pick_stop;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_done_onehot;
  logic [NUM_REQ-1:0] r_done_valid;
  logic               w_accept;
  logic               w_hit;
  logic               r_busy;
  logic               r_load_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req        (bus.Req_Valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant)
  );

  assign w_ready       = (r_state == IDLE) ? w_arb_grant : '0;
  assign w_accept      = |(bus.Req_Valid & w_ready);
  // Exact-width equality, so a stop below start is reached after the wrap.
  assign w_hit         = (bus.Count == r_stop_q);
  assign w_done_onehot = NUM_REQ'(1) << r_id_q;

  // Encode the winner and pull its start/stop slices off the packed buses.
  always_comb begin
    w_pick_id    = '0;
    w_pick_start = '0;
    w_pick_stop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_pick_id    = ID_W'(i);
        w_pick_start = bus.Req_Start[i*WIDTH +: WIDTH];
        w_pick_stop  = bus.Req_Stop[i*WIDTH +: WIDTH];
      end
    end
  end

  // Session sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = RUN;
      RUN:     if (w_hit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured session parameters and the round-robin pointer.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id_q       <= '0;
      r_stop_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_accept) begin
        r_id_q   <= w_pick_id;
        r_stop_q <= w_pick_stop;
      end
      // The pointer only moves on completion, so an aborted session leaves it alone.
      if (r_state == DONE) begin
        r_last_grant <= r_id_q;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // The start value is captured straight into the load register; it is only needed in LOAD.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      r_busy       <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_value <= '0;
      r_done_valid <= '0;
    end else begin
      r_busy       <= (w_state_nxt != IDLE);
      r_load_valid <= (w_state_nxt == LOAD);
      r_load_value <= (w_state_nxt == LOAD) ? w_pick_start : '0;
      r_done_valid <= (w_state_nxt == DONE) ? w_done_onehot : '0;
    end
  end

  assign bus.Req_Ready        = w_ready;
  assign bus.Done_Valid       = r_done_valid;
  assign bus.Busy             = r_busy;
  assign bus.Grant_Id         = r_id_q;
  assign bus.Load_Value_Valid = r_load_valid;
  assign bus.Load_Value       = r_load_value;

endmodule

// File: doc/load_counter_scheduler.md
# load_counter_scheduler

Round-robin scheduler that shares one loadable up-counter between NUM_REQ requesters. Each granted requester supplies a start and a stop value. The scheduler loads the start value into the counter, watches Count until it equals the stop value, then pulses a per-requester done. It sits between the requesting blocks and the counter's Load_Value_Valid / Load_Value / Count ports.

## Interface
- WIDTH, 4, width of counter, start and stop values
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, $clog2(NUM_REQ), width of Grant_Id (derived, not overridden)

- Clk  input  1  clock, all state on rising edge
- Rst_l  input  1  reset, asynchronous, active-low
- Req_Valid  input  NUM_REQ  per-requester request, held until accepted
- Req_Ready  output  NUM_REQ  one-hot accept; handshake = Req_Valid[i] & Req_Ready[i]
- Req_Start  input  NUM_REQ*WIDTH  packed start values, slice i = [i*WIDTH +: WIDTH]
- Req_Stop  input  NUM_REQ*WIDTH  packed stop values, same packing
- Done_Valid  output  NUM_REQ  one-hot, one-cycle completion pulse
- Busy  output  1  high whenever state ≠ IDLE
- Grant_Id  output  ID_W  index of the current or last granted requester
- Load_Value_Valid  output  1  load strobe to counter
- Load_Value  output  WIDTH  value to load; 0 when strobe low
- Count  input  WIDTH  counter output

## Operation
- Counter behaviour:
  - Load_Value_Valid high at an edge loads Load_Value.
  - Otherwise the counter increments by 1, wrapping 2^WIDTH−1 → 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Req_Ready is the combinational round-robin pick among asserted Req_Valid bits.
  - Search order starts at last_grant+1 (mod NUM_REQ).
  - Req_Ready is all-zero if no request is pending.
  - On handshake, register start_q, stop_q and id_q (Grant_Id), then go to LOAD.
- LOAD: Load_Value_Valid=1, Load_Value=start_q for exactly one cycle, then go to RUN.
- RUN:
  - Compare Count with stop_q every cycle.
  - On equality, go to DONE.
  - The comparison is exact WIDTH-bit equality, so wrap-around is implicit. Equality is guaranteed within 2^WIDTH cycles, so no watchdog is required.
- DONE:
  - Done_Valid[id_q]=1 for one cycle.
  - last_grant ← id_q.
  - Go to IDLE.
- Req_Ready is zero in LOAD, RUN and DONE. Requests stay pending and are not dropped.
- Changes to Req_Start/Req_Stop after acceptance have no effect on the running session.

## Timing
- Reset (asynchronous):
  - state=IDLE, last_grant=NUM_REQ−1 (requester 0 has first priority).
  - Registered outputs Done_Valid, Busy, Grant_Id, Load_Value_Valid and Load_Value are all 0.
  - Req_Ready is combinational and follows the IDLE arbitration rule: all-zero while no Req_Valid is asserted.
- Session length, with d = (stop − start) mod 2^WIDTH:
  - 1 accept cycle (IDLE), 1 LOAD cycle, d+1 RUN cycles, 1 DONE cycle.
  - The first RUN cycle sees Count = start.
- start == stop: exactly one RUN cycle.
- Busy rises the cycle after acceptance and falls the cycle after DONE.
- Back-to-back: the earliest next acceptance is the IDLE cycle immediately after DONE.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by the round-robin rule.
- Reset mid-session:
  - Immediate return to IDLE.
  - No Done_Valid is issued.
  - The aborted requester is not re-granted until it re-asserts its request after reset.

## Structure
- Package load_sched_pkg:
  - state enum type (IDLE, LOAD, RUN, DONE)
  - ID-width helper function
- Sub-module rr_arbiter:
  - parameter NUM_REQ
  - inputs: req vector, last_grant pointer
  - output: one-hot grant
  - purely combinational, mask-and-priority implementation
- Top holds the FSM, capture registers, comparator and last_grant register.

## Test plan
- Requester 0, start 0xA, stop 0xD:
  - Req_Ready[0] is high in the request cycle.
  - One Load_Value_Valid pulse with Load_Value=0xA.
  - 4 RUN cycles (A,B,C,D), then Done_Valid[0] pulses once.
  - Busy is high for 6 cycles.
- Wrap case, start 0xE, stop 0x1: RUN sees E,F,0,1 (4 cycles), then Done_Valid pulses.
- start = stop = 0x5: exactly 1 RUN cycle, Done_Valid in the third cycle after acceptance.
- All four Req_Valid held high, each with start 0x0, stop 0x2: grant order 0,1,2,3,0; no Done is missed or duplicated.
- Requester 2 granted first; requesters 1 and 3 assert during its session: next grants are 3, then 1.
- Rst_l pulled low in the middle of RUN:
  - All registered outputs go to 0 asynchronously.
  - No Done_Valid is issued.
  - After release with all requesters pending, requester 0 is granted first.
